// File: rtl/md_seq.sv
// Multiply/divide sequencer with architectural HI/LO registers.
// Holds operands for a fixed number of busy cycles, then commits the result to HI/LO.
module md_seq #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        md_use_id,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = ($clog2(MAX_CYC + 1) < 4) ? 4 : $clog2(MAX_CYC + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Full 64-bit product; sign-extending both operands makes the low 64 bits the signed product.
    function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y,
                                          input logic is_signed);
        logic [63:0] ex;
        logic [63:0] ey;
        ex = is_signed ? {{32{x[31]}}, x} : {32'd0, x};
        ey = is_signed ? {{32{y[31]}}, y} : {32'd0, y};
        return ex * ey;
    endfunction

    // Returns {remainder, quotient}; signed case divides magnitudes, then restores signs,
    // which also yields 0x80000000 / -1 = 0x80000000 rem 0 without overflow.
    function automatic logic [63:0] div64(input logic [31:0] x, input logic [31:0] y,
                                          input logic is_signed);
        logic        x_neg;
        logic        y_neg;
        logic [31:0] x_mag;
        logic [31:0] y_mag;
        logic [31:0] q;
        logic [31:0] r;
        x_neg = is_signed & x[31];
        y_neg = is_signed & y[31];
        x_mag = x_neg ? (32'd0 - x) : x;
        y_mag = y_neg ? (32'd0 - y) : y;
        q = (y_mag == 32'd0) ? 32'd0 : (x_mag / y_mag);
        r = (y_mag == 32'd0) ? 32'd0 : (x_mag % y_mag);
        return {(x_neg ? (32'd0 - r) : r), ((x_neg ^ y_neg) ? (32'd0 - q) : q)};
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic [31:0]       a_r;
    logic [31:0]       a_s;
    logic [31:0]       b_r;
    logic [31:0]       b_s;
    logic [1:0]        op_r;
    logic [1:0]        op_s;
    logic [31:0]       hi_r;
    logic [31:0]       hi_s;
    logic [31:0]       lo_r;
    logic [31:0]       lo_s;
    logic [63:0]       mul_res_s;
    logic [63:0]       div_res_s;
    logic              div_zero_s;

    assign mul_res_s  = mul64(a_r, b_r, ~op_r[0]);
    assign div_res_s  = div64(a_r, b_r, ~op_r[0]);
    assign div_zero_s = (b_r == 32'd0);

    assign busy     = (state_r == BUSY);
    assign stall_md = md_use_id & (start | busy);
    assign hi       = hi_r;
    assign lo       = lo_r;

    // Next-state, counter, operand latch and HI/LO update logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        a_s     = a_r;
        b_s     = b_r;
        op_s    = op_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    a_s     = a;
                    b_s     = b;
                    op_s    = op;
                    cnt_s   = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                    state_s = BUSY;
                end else begin
                    if (mthi) begin
                        hi_s = wdata;
                    end else begin
                        hi_s = hi_r;
                    end
                    if (mtlo) begin
                        lo_s = wdata;
                    end else begin
                        lo_s = lo_r;
                    end
                end
            end
            BUSY: begin
                // start/mthi/mtlo are deliberately not looked at while busy.
                if (cnt_r <= CNT_W'(1)) begin
                    cnt_s   = '0;
                    state_s = IDLE;
                    if (!op_r[1]) begin
                        hi_s = mul_res_s[63:32];
                        lo_s = mul_res_s[31:0];
                    end else if (!div_zero_s) begin
                        hi_s = div_res_s[63:32];
                        lo_s = div_res_s[31:0];
                    end else begin
                        hi_s = hi_r;
                        lo_s = lo_r;
                    end
                end else begin
                    cnt_s   = cnt_r - CNT_W'(1);
                    state_s = BUSY;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // State, counter, latched operands and architectural HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            op_r    <= 2'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            a_r     <= a_s;
            b_r     <= b_s;
            op_r    <= op_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
        end
    end

endmodule

// File: tb/tb_md_seq.sv
// Scoreboard bench for md_seq: expected HI/LO and busy length are queued at issue
// and compared when busy falls; stalls, ignored moves and reset abort are checked inline.
module tb_md_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        md_use_id;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_hi     = 32'd0;
    logic [31:0] m_lo     = 32'd0;
    int          bcnt     = 0;
    logic        prev_busy = 1'b0;

    md_seq #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .md_use_id(md_use_id),
        .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard monitor: count busy cycles, compare results when busy falls.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            bcnt = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) begin
                bcnt++;
            end else if (prev_busy) begin
                if (sb.size() == 0) begin
                    check_eq("sb_nonempty", 64'(sb.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("busy_len", 64'(bcnt), 64'(e.len));
                    check_eq("hi", {32'd0, hi}, {32'd0, e.hi});
                    check_eq("lo", {32'd0, lo}, {32'd0, e.lo});
                end
                bcnt = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] e_hi, input logic [31:0] e_lo, input int len,
                          input logic use_id, input logic junk, input logic move_too);
        exp_t        e;
        logic [31:0] prev_hi;
        int          k;
        prev_hi = m_hi;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; md_use_id = use_id;
        mthi = move_too; wdata = 32'hBAD0_BAD0;
        e.hi = e_hi; e.lo = e_lo; e.len = len;
        sb.push_back(e);
        m_hi = e_hi; m_lo = e_lo;
        #1;
        check_eq("stall_start", {63'd0, stall_md}, {63'd0, use_id});
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        if (move_too) begin
            check_eq("move_lost_to_start", {32'd0, hi}, {32'd0, prev_hi});
        end
        k = 0;
        while (busy && k < 40) begin
            check_eq("stall_busy", {63'd0, stall_md}, {63'd0, use_id});
            if (junk && k == 1) begin
                mtlo = 1'b1; mthi = 1'b1; start = 1'b1; op = 2'b01;
                a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; wdata = 32'hDEAD_BEEF;
            end else begin
                mtlo = 1'b0; mthi = 1'b0; start = 1'b0;
            end
            k++;
            @(negedge clk);
        end
        mtlo = 1'b0; mthi = 1'b0; start = 1'b0;
        if (k >= 40) begin
            check_eq("busy_timeout", {63'd0, busy}, 64'd0);
        end
        #1;
        check_eq("stall_after", {63'd0, stall_md}, 64'd0);
        md_use_id = 1'b0;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rh;
        logic [31:0] rl;
        longint      p;
        int          sa;
        int          sbv;
        rst_n = 1'b0; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
        mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0; md_use_id = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_hilo", {hi, lo}, 64'd0);
        md_use_id = 1'b1; start = 1'b1;
        #1;
        check_eq("rst_stall_start", {63'd0, stall_md}, 64'd1);
        start = 1'b0;
        #1;
        check_eq("rst_stall_idle", {63'd0, stall_md}, 64'd0);
        md_use_id = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1'b0, 1'b0, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, 1'b0, 1'b0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0, 1'b0, 1'b0);
        run_op(2'b11, 32'd7, 32'd0, m_hi, m_lo, 10, 1'b0, 1'b0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 1'b0, 1'b0, 1'b0);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10, 1'b0, 1'b0, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1'b0, 1'b0, 1'b0);
        // stall through completion, with mtlo/mthi/start pulsed mid-busy
        run_op(2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 5, 1'b1, 1'b1, 1'b0);

        // IDLE moves
        @(negedge clk);
        mthi = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        mthi = 1'b0;
        check_eq("mthi", {hi, lo}, {32'h1234_5678, m_lo});
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check_eq("mthi_mtlo", {hi, lo}, {32'hA5A5_A5A5, 32'hA5A5_A5A5});
        m_hi = 32'hA5A5_A5A5; m_lo = 32'hA5A5_A5A5;

        // start wins over a simultaneous mthi
        run_op(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 5, 1'b0, 1'b0, 1'b1);

        // small randomized set against a native-arithmetic model
        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (rb == 32'd0) rb = 32'd1;
            if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
            sa = ra; sbv = rb;
            case (ro)
                2'b00: begin p = longint'(sa) * longint'(sbv); rh = p[63:32]; rl = p[31:0]; end
                2'b01: begin p = longint'({32'd0, ra}) * longint'({32'd0, rb}); rh = p[63:32]; rl = p[31:0]; end
                2'b10: begin rl = sa / sbv; rh = sa % sbv; end
                default: begin rl = ra / rb; rh = ra % rb; end
            endcase
            run_op(ro, ra, rb, rh, rl, ro[1] ? 10 : 5, 1'b0, 1'b0, 1'b0);
        end

        // reset mid-operation at busy cycle 3
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("abort_busy_before", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", {63'd0, busy}, 64'd0);
        check_eq("abort_hilo", {hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("abort_no_write", {hi, lo}, 64'd0);
        check_eq("abort_idle", {63'd0, busy}, 64'd0);
        check_eq("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/md_seq.md
MD_SEQ -- requirements
Module: md_seq

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 5, meaning the number of busy cycles for MULT and MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning the number of busy cycles for DIV and DIVU.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  EX-stage mult/div issue pulse.
REQ-006 SHALL have port op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 SHALL have ports a and b  input  32 each  rs and rt operands.
REQ-008 SHALL have ports mthi and mtlo  input  1 each  EX-stage MTHI and MTLO write enables.
REQ-009 SHALL have port wdata  input  32  MTHI/MTLO data.
REQ-010 SHALL have port md_use_id  input  1  ID-stage instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
REQ-011 SHALL have port busy  output  1  an operation is in progress.
REQ-012 SHALL have port stall_md  output  1  stall request, ORed into the pipeline stall.
REQ-013 SHALL have ports hi and lo  output  32 each  architectural HI/LO, registered.

Function
REQ-014 SHALL implement FSM states IDLE and BUSY with a down-counter cnt of at least 4 bits.
- IDLE: start=1 is accepted on the clock edge.
REQ-015 On acceptance SHALL latch a, b and op, load cnt with MUL_CYCLES (op[1]=0) or DIV_CYCLES (op[1]=1), and enter BUSY.
REQ-016 busy SHALL be 1 exactly when state=BUSY, giving N consecutive busy cycles starting the cycle after start.
REQ-017 In BUSY, cnt SHALL decrement by one each cycle.
REQ-018 At the edge where state=BUSY and cnt=1, the FSM SHALL write hi/lo and return to IDLE.
- Result is visible the same cycle busy falls.
REQ-019 MULT SHALL compute the signed 64-bit product of the latched operands: hi = bits [63:32], lo = bits [31:0].
REQ-020 MULTU SHALL compute the same split using the unsigned product.
REQ-021 DIV SHALL set lo = signed quotient truncated toward zero and hi = remainder with the sign of the dividend.
REQ-022 DIVU SHALL set lo and hi to the unsigned quotient and remainder.
REQ-023 Division by zero SHALL still take DIV_CYCLES busy cycles and leave hi and lo unchanged.
REQ-024 The combination 0x80000000 / 0xFFFFFFFF under DIV SHALL give lo = 0x80000000 and hi = 0.
REQ-025 start, mthi and mtlo asserted while BUSY SHALL be ignored, with no state change.
REQ-026 In IDLE, mthi SHALL write hi <= wdata and mtlo SHALL write lo <= wdata on the edge.
- Both asserted together: both registers are written.
REQ-027 If start and mthi/mtlo are asserted together in IDLE, start SHALL win and the move SHALL be ignored.
REQ-028 stall_md SHALL equal md_use_id & (start | busy), combinational.
- Holds a dependent ID-stage instruction until the cycle busy falls.
REQ-029 The outputs hi and lo SHALL change only at a completion edge, an MTHI/MTLO edge, or reset.

Reset
REQ-030 While rst_n=0, the block SHALL immediately force state=IDLE, cnt=0, busy=0, hi=0, lo=0, and clear the latched operands.
- stall_md then reduces to md_use_id & start.
REQ-031 Reset asserted mid-operation SHALL abort the operation with no HI/LO write.
- The first edge after rst_n rises behaves as IDLE.

Verification
REQ-032 Bench SHALL cover MULT: start with a=0xFFFFFFFE, b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-033 Bench SHALL cover MULTU: a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-034 Bench SHALL cover DIV: a=0xFFFFFFF9 (-7), b=2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Then DIVU with a=7, b=0 -> hi/lo unchanged after 10 busy cycles.
REQ-035 Bench SHALL cover stalls and ignored writes: md_use_id=1 held from start through completion -> stall_md=1 on the start cycle and all busy cycles, then 0 on the cycle busy falls.
- mtlo pulsed mid-BUSY -> lo unaffected.
REQ-036 Bench SHALL cover IDLE moves and reset: mthi with wdata=0x12345678 in IDLE -> hi=0x12345678 next cycle.
- Pulsing rst_n low at busy cycle 3 of a MULT -> busy=0, hi=lo=0 immediately, with no later write.
